// File: rtl/torrence_types.sv
// Shared type package: memory operation encoding and the responder FSM state.
package torrence_types;

    typedef enum logic {
        LOAD  = 1'b0,
        STORE = 1'b1
    } memory_operation_e;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        RESPOND = 2'd2
    } hmem_responder_state_e;

endpackage

// File: rtl/higher_memory_responder_if.sv
// Request/response bus between an initiator (master) and the memory responder (slave).
// Handshake: the responder accepts while idle and req_valid=1; req_fulfilled pulses one cycle per accepted request.
interface higher_memory_responder_if #(
    parameter int XLEN = 32
) ();
    import torrence_types::*;

    logic              req_valid;
    memory_operation_e req_operation;
    logic [XLEN-1:0]   req_address;
    logic [XLEN-1:0]   req_store_word;
    logic [XLEN-1:0]   req_loaded_word;
    logic              req_fulfilled;
    logic              req_error;

    modport master (
        output req_valid, req_operation, req_address, req_store_word,
        input  req_loaded_word, req_fulfilled, req_error
    );

    modport slave (
        input  req_valid, req_operation, req_address, req_store_word,
        output req_loaded_word, req_fulfilled, req_error
    );
endinterface

// File: rtl/counter.sv
// Loadable down-counter that saturates at zero; synchronous active-low reset.
module counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             dec,
    output logic [WIDTH-1:0] count
);
    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_value;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
endmodule

// File: rtl/higher_memory_responder.sv
// Fixed-latency word memory responder (IDLE -> WAIT x LATENCY -> RESPOND).
// Optional access statistics are enabled by defining HMEM_ACCESS_STATS_EN.
module higher_memory_responder
    import torrence_types::*;
#(
    parameter int XLEN     = 32,
    parameter int MEM_SIZE = 4096,
    parameter int LATENCY  = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    higher_memory_responder_if.slave bus,
    output logic [31:0]           read_count,
    output logic [31:0]           write_count,
    output hmem_responder_state_e state_dbg
);
    localparam int AW    = $clog2(MEM_SIZE);
    localparam int DEPTH = MEM_SIZE / 4;

    logic [XLEN-1:0] mem [DEPTH];

    hmem_responder_state_e state_q, state_d;
    memory_operation_e     op_q, op_d;
    logic [XLEN-1:0]       addr_q, addr_d;
    logic [XLEN-1:0]       wdata_q, wdata_d;
    logic [XLEN-1:0]       rdata_q, rdata_d;
    logic                  fulfilled_q, fulfilled_d;
    logic                  error_q, error_d;
    logic                  cnt_load, cnt_dec;
    logic [7:0]            count;
    logic                  mem_we;

    function automatic logic addr_bad(input logic [XLEN-1:0] a);
        return (a >= XLEN'(MEM_SIZE)) || (a[1:0] != 2'b00);
    endfunction

    counter #(.WIDTH(8)) u_latency_counter (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (cnt_load),
        .load_value (8'(LATENCY)),
        .dec        (cnt_dec),
        .count      (count)
    );

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        fulfilled_d = 1'b0;
        error_d     = 1'b0;
        cnt_load    = 1'b0;
        cnt_dec     = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    op_d     = bus.req_operation;
                    addr_d   = bus.req_address;
                    wdata_d  = bus.req_store_word;
                    cnt_load = 1'b1;
                    state_d  = (LATENCY == 0) ? RESPOND : WAIT;
                end
            end
            WAIT: begin
                cnt_dec = 1'b1;
                // Leaving when the counter steps 1 -> 0 gives exactly LATENCY wait cycles.
                if (count <= 8'd1) begin
                    state_d = RESPOND;
                end
            end
            RESPOND: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Response outputs are registered on entry so they are valid throughout RESPOND.
        if ((state_d == RESPOND) && (state_q != RESPOND)) begin
            fulfilled_d = 1'b1;
            error_d     = addr_bad(addr_d);
            if (error_d) begin
                rdata_d = '0;
            end else if (op_d == LOAD) begin
                rdata_d = mem[addr_d[AW-1:2]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            op_q        <= LOAD;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            fulfilled_q <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            fulfilled_q <= fulfilled_d;
            error_q     <= error_d;
        end
    end

    // The store commits on the edge that closes RESPOND, so a reset in RESPOND drops it.
    assign mem_we = reset_n && (state_q == RESPOND) && (op_q == STORE) && !error_q;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[addr_q[AW-1:2]] <= wdata_q;
        end
    end

    assign bus.req_fulfilled   = fulfilled_q;
    assign bus.req_error       = error_q;
    assign bus.req_loaded_word = rdata_q;
    assign state_dbg           = state_q;

`ifdef HMEM_ACCESS_STATS_EN
    logic [31:0] read_count_q, read_count_d;
    logic [31:0] write_count_q, write_count_d;

    always_comb begin
        read_count_d  = read_count_q;
        write_count_d = write_count_q;
        if ((state_q == RESPOND) && !error_q) begin
            if (op_q == LOAD) begin
                read_count_d = read_count_q + 32'd1;
            end else begin
                write_count_d = write_count_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            read_count_q  <= '0;
            write_count_q <= '0;
        end else begin
            read_count_q  <= read_count_d;
            write_count_q <= write_count_d;
        end
    end

    assign read_count  = read_count_q;
    assign write_count = write_count_q;
`else
    assign read_count  = '0;
    assign write_count = '0;
`endif
endmodule

// File: tb/tb_higher_memory_responder.sv
// Directed self-checking bench for higher_memory_responder (LATENCY=4 and LATENCY=0 instances).
module tb_higher_memory_responder;
    import torrence_types::*;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    higher_memory_responder_if #(.XLEN(32)) bus ();
    higher_memory_responder_if #(.XLEN(32)) bus0 ();

    logic [31:0]           rc, wc, rc0, wc0;
    hmem_responder_state_e st, st0;

    higher_memory_responder #(.XLEN(32), .MEM_SIZE(4096), .LATENCY(4)) u_dut (
        .clk(clk), .reset_n(reset_n), .bus(bus.slave),
        .read_count(rc), .write_count(wc), .state_dbg(st)
    );

    higher_memory_responder #(.XLEN(32), .MEM_SIZE(4096), .LATENCY(0)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .bus(bus0.slave),
        .read_count(rc0), .write_count(wc0), .state_dbg(st0)
    );

    int checks = 0;
    int fails  = 0;

`ifdef HMEM_ACCESS_STATS_EN
    localparam logic [31:0] STATS_FILL = 32'd8;
`else
    localparam logic [31:0] STATS_FILL = 32'd0;
`endif

    initial begin
        bus.req_valid = 1'b0;
        bus.req_operation = LOAD;
        bus.req_address = '0;
        bus.req_store_word = '0;
        bus0.req_valid = 1'b0;
        bus0.req_operation = LOAD;
        bus0.req_address = '0;
        bus0.req_store_word = '0;
    end

    // Issue one request on the LATENCY=4 instance; n = negedges from issue to pulse (-1 on timeout).
    task automatic do_access(input memory_operation_e op, input logic [31:0] addr,
                             input logic [31:0] data, output int n,
                             output logic [31:0] rdata, output logic err, output logic leak);
        n = -1;
        rdata = '0;
        err = 1'b0;
        leak = 1'b0;
        @(negedge clk);
        bus.req_operation = op;
        bus.req_address = addr;
        bus.req_store_word = data;
        bus.req_valid = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1) bus.req_valid = 1'b0;
            if (!bus.req_fulfilled && bus.req_error) leak = 1'b1;
            if (bus.req_fulfilled) begin
                n = k;
                rdata = bus.req_loaded_word;
                err = bus.req_error;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (bus.req_fulfilled !== 1'b0) begin fails++; $display("FAIL reset_fulfilled: got %b expected 0", bus.req_fulfilled); end
        checks++; if (bus.req_error !== 1'b0) begin fails++; $display("FAIL reset_error: got %b expected 0", bus.req_error); end
        checks++; if (bus.req_loaded_word !== 32'h0) begin fails++; $display("FAIL reset_loaded_word: got %h expected 0", bus.req_loaded_word); end
        checks++; if (rc !== 32'h0 || wc !== 32'h0) begin fails++; $display("FAIL reset_counts: got %0d/%0d expected 0/0", rc, wc); end
        checks++; if (st !== IDLE || st0 !== IDLE) begin fails++; $display("FAIL reset_state: got %0d/%0d expected IDLE", st, st0); end
        reset_n = 1'b1;
    endtask

    task automatic test_write_read();
        int n; logic [31:0] rd; logic er, lk;
        do_access(STORE, 32'h40, 32'hDEADBEEF, n, rd, er, lk);
        checks++; if (n !== 5 || er !== 1'b0 || lk !== 1'b0) begin fails++; $display("FAIL store_0x40: got n=%0d err=%b leak=%b expected n=5 err=0 leak=0", n, er, lk); end
        do_access(LOAD, 32'h40, 32'h0, n, rd, er, lk);
        checks++; if (rd !== 32'hDEADBEEF || er !== 1'b0) begin fails++; $display("FAIL load_0x40: got %h err=%b expected deadbeef err=0", rd, er); end
    endtask

    task automatic test_latency();
        int n; logic [31:0] rd; logic er, lk;
        do_access(LOAD, 32'h40, 32'h0, n, rd, er, lk);
        checks++; if (n !== 5) begin fails++; $display("FAIL latency4_pulse: got cycle %0d expected 5", n); end
        @(negedge clk);
        checks++; if (bus.req_fulfilled !== 1'b0) begin fails++; $display("FAIL latency4_width: got %b expected 0", bus.req_fulfilled); end
        // LATENCY=0 instance: STORE then LOAD, each pulsing the cycle after issue.
        bus0.req_operation = STORE;
        bus0.req_address = 32'h10;
        bus0.req_store_word = 32'hCAFE0010;
        bus0.req_valid = 1'b1;
        @(negedge clk);
        bus0.req_valid = 1'b0;
        checks++; if (bus0.req_fulfilled !== 1'b1) begin fails++; $display("FAIL latency0_store_pulse: got %b expected 1", bus0.req_fulfilled); end
        @(negedge clk);
        checks++; if (bus0.req_fulfilled !== 1'b0) begin fails++; $display("FAIL latency0_width: got %b expected 0", bus0.req_fulfilled); end
        bus0.req_operation = LOAD;
        bus0.req_valid = 1'b1;
        @(negedge clk);
        bus0.req_valid = 1'b0;
        checks++; if (bus0.req_fulfilled !== 1'b1 || bus0.req_loaded_word !== 32'hCAFE0010) begin
            fails++; $display("FAIL latency0_load: got pulse=%b data=%h expected 1 cafe0010", bus0.req_fulfilled, bus0.req_loaded_word);
        end
    endtask

    task automatic test_errors();
        int n; logic [31:0] rd; logic er, lk;
        do_access(LOAD, 32'h1000, 32'h0, n, rd, er, lk);
        checks++; if (n !== 5 || er !== 1'b1 || rd !== 32'h0) begin fails++; $display("FAIL err_load_0x1000: got n=%0d err=%b data=%h expected 5 1 0", n, er, rd); end
        do_access(LOAD, 32'h40, 32'h0, n, rd, er, lk);
        checks++; if (rd !== 32'hDEADBEEF || er !== 1'b0) begin fails++; $display("FAIL err_reload: got %h err=%b expected deadbeef 0", rd, er); end
        do_access(STORE, 32'h42, 32'h12345678, n, rd, er, lk);
        checks++; if (n !== 5 || er !== 1'b1 || rd !== 32'h0 || lk !== 1'b0) begin fails++; $display("FAIL err_store_0x42: got n=%0d err=%b data=%h leak=%b expected 5 1 0 0", n, er, rd, lk); end
        do_access(LOAD, 32'h40, 32'h0, n, rd, er, lk);
        checks++; if (rd !== 32'hDEADBEEF || er !== 1'b0) begin fails++; $display("FAIL err_no_write: got %h err=%b expected deadbeef 0", rd, er); end
    endtask

    task automatic test_mid_reset();
        int n; logic [31:0] rd; logic er, lk; logic seen;
        do_access(STORE, 32'h80, 32'hA5A50080, n, rd, er, lk);
        @(negedge clk);
        bus.req_operation = STORE;
        bus.req_address = 32'h80;
        bus.req_store_word = 32'h11111111;
        bus.req_valid = 1'b1;
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        checks++; if (st !== WAIT) begin fails++; $display("FAIL midreset_in_wait: got %0d expected WAIT", st); end
        reset_n = 1'b0;
        seen = 1'b0;
        repeat (2) begin @(negedge clk); if (bus.req_fulfilled) seen = 1'b1; end
        reset_n = 1'b1;
        @(negedge clk);
        checks++; if (st !== IDLE) begin fails++; $display("FAIL midreset_state: got %0d expected IDLE", st); end
        repeat (7) begin @(negedge clk); if (bus.req_fulfilled) seen = 1'b1; end
        checks++; if (seen !== 1'b0) begin fails++; $display("FAIL midreset_pulse: got %b expected 0", seen); end
        do_access(LOAD, 32'h80, 32'h0, n, rd, er, lk);
        checks++; if (rd !== 32'hA5A50080 || er !== 1'b0) begin fails++; $display("FAIL midreset_old_value: got %h expected a5a50080", rd); end
    endtask

    task automatic test_back_to_back();
        int n; logic [31:0] rd; logic er, lk;
        logic [31:0] wc_start, rc_start;
        int gap;
        wc_start = wc;
        for (int i = 0; i < 8; i++) begin
            do_access(STORE, 32'h20 + 32'(4 * i), 32'hF0000020 + 32'(4 * i), n, rd, er, lk);
        end
        @(negedge clk);
        checks++; if (wc - wc_start !== STATS_FILL) begin fails++; $display("FAIL fill_write_count: got %0d expected %0d", wc - wc_start, STATS_FILL); end
        rc_start = rc;
        bus.req_operation = LOAD;
        bus.req_address = 32'h20;
        bus.req_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            gap = -1;
            for (int k = 1; k <= 20; k++) begin
                @(negedge clk);
                if (bus.req_fulfilled) begin gap = k; break; end
            end
            checks++; if (gap !== ((i == 0) ? 5 : 6)) begin fails++; $display("FAIL fill_spacing[%0d]: got %0d expected %0d", i, gap, (i == 0) ? 5 : 6); end
            checks++; if (bus.req_loaded_word !== 32'hF0000020 + 32'(4 * i) || bus.req_error !== 1'b0) begin
                fails++; $display("FAIL fill_data[%0d]: got %h err=%b expected %h", i, bus.req_loaded_word, bus.req_error, 32'hF0000020 + 32'(4 * i));
            end
            if (i == 7) bus.req_valid = 1'b0;
            else bus.req_address = 32'h20 + 32'(4 * (i + 1));
        end
        repeat (2) @(negedge clk);
        checks++; if (rc - rc_start !== STATS_FILL) begin fails++; $display("FAIL fill_read_count: got %0d expected %0d", rc - rc_start, STATS_FILL); end
    endtask

    task automatic test_stability();
        int n; logic [31:0] rd; logic er, lk;
        do_access(STORE, 32'h44, 32'h44444444, n, rd, er, lk);
        @(negedge clk);
        bus.req_operation = LOAD;
        bus.req_address = 32'h40;
        bus.req_valid = 1'b1;
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_operation = STORE;
        bus.req_address = 32'h44;
        bus.req_store_word = 32'h99999999;
        n = -1;
        for (int k = 2; k <= 20; k++) begin
            @(negedge clk);
            if (bus.req_fulfilled) begin n = k; break; end
        end
        checks++; if (n !== 5 || bus.req_loaded_word !== 32'hDEADBEEF || bus.req_error !== 1'b0) begin
            fails++; $display("FAIL stability_load: got n=%0d data=%h expected 5 deadbeef", n, bus.req_loaded_word);
        end
        do_access(LOAD, 32'h44, 32'h0, n, rd, er, lk);
        checks++; if (rd !== 32'h44444444) begin fails++; $display("FAIL stability_no_store: got %h expected 44444444", rd); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_latency();
        test_errors();
        test_mid_reset();
        test_back_to_back();
        test_stability();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/higher_memory_responder.md
HIGHER_MEMORY_RESPONDER -- requirements
Module: higher_memory_responder

Interface
REQ-001 SHALL have parameter XLEN, default 32, the word width; only 32 is legal.
REQ-002 SHALL have parameter MEM_SIZE, default 4096, the backing-store size in bytes; it is a power of two and divisible by 4.
REQ-003 SHALL have parameter LATENCY, default 4, the number of wait cycles between request acceptance and response; legal range 0..255.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port reset_n, input, 1 bit: reset, synchronous and active-low.
REQ-006 SHALL have port req_valid, input, 1 bit: the initiator has a request pending.
REQ-007 SHALL have port req_operation, input, memory_operation_e: LOAD or STORE.
REQ-008 SHALL have port req_address, input, XLEN bits: byte address, word-aligned.
REQ-009 SHALL have port req_store_word, input, XLEN bits: write data.
REQ-010 SHALL have port req_loaded_word, output, XLEN bits: read data.
REQ-011 SHALL have port req_fulfilled, output, 1 bit: one-cycle response pulse.
REQ-012 SHALL have port req_error, output, 1 bit: qualifies req_fulfilled; the access was rejected.
REQ-013 SHALL have ports read_count and write_count, outputs, 32 bits each: access statistics (see Configuration).

Function
REQ-014 SHALL implement an FSM with states IDLE, WAIT and RESPOND.
REQ-015 SHALL accept a request in IDLE when req_valid=1, capturing operation, address and store word into registers on that edge.
REQ-016 SHALL, on acceptance, go to WAIT and load the latency counter with LATENCY; if LATENCY=0 it SHALL go directly to RESPOND.
REQ-017 SHALL decrement the counter once per cycle in WAIT and go to RESPOND in the cycle after it reaches 0, giving exactly LATENCY WAIT cycles.
REQ-018 SHALL assert req_fulfilled for exactly one cycle, in RESPOND, then return to IDLE.
REQ-019 SHALL accept a new request no earlier than the cycle after RESPOND; back-to-back throughput is one request per LATENCY+2 cycles.
REQ-020 SHALL use only the captured request fields; changes on req_* or deassertion of req_valid after acceptance SHALL NOT alter or abort the access.
REQ-021 SHALL, for a LOAD, drive req_loaded_word with mem[captured_address/4] from the RESPOND cycle and hold it until the next RESPOND.
REQ-022 SHALL, for a STORE, write the full word into the array on the RESPOND edge; req_loaded_word is unchanged by a STORE.
REQ-023 SHALL flag an error when captured_address >= MEM_SIZE or captured_address[1:0] != 0.
REQ-024 SHALL, for an errored access, pulse req_fulfilled together with req_error=1, perform no write, and drive req_loaded_word to 0.
REQ-025 SHALL drive req_error=0 whenever req_fulfilled=0.
REQ-026 SHALL return, for a LOAD issued immediately after a STORE to the same address, the newly stored word.

Reset
REQ-027 SHALL, while reset_n=0 at a rising edge, force state IDLE, counter 0, req_fulfilled=0, req_error=0, req_loaded_word=0, read_count=0 and write_count=0.
REQ-028 SHALL, on reset during WAIT or RESPOND, abort the access with no write and no req_fulfilled pulse.
REQ-029 SHALL NOT clear or alter the memory array contents on reset.

Configuration
REQ-030 SHALL use the macro HMEM_ACCESS_STATS_EN: when defined, read_count and write_count increment on each successful LOAD or STORE respectively in RESPOND, wrap modulo 2^32, and do not count errored accesses.
REQ-031 SHALL, when HMEM_ACCESS_STATS_EN is undefined, tie read_count and write_count to constant 0 and synthesize no counter logic for them.

Structure
REQ-032 SHALL take memory_operation_e from the shared package torrence_types, and SHALL add hmem_responder_state_e (IDLE/WAIT/RESPOND) to that package.
REQ-033 SHALL implement the latency countdown as an instance of the existing counter sub-module with WIDTH=8.
REQ-034 SHALL size the array as MEM_SIZE/4 words of XLEN bits, indexed by captured_address[$clog2(MEM_SIZE)-1:2].

Verification
REQ-035 SHALL verify write then read: STORE 0xDEADBEEF to 0x40, then LOAD 0x40 -> req_loaded_word=0xDEADBEEF, req_error=0.
REQ-036 SHALL verify latency: with LATENCY=4, req_valid rising at cycle N -> req_fulfilled high only at cycle N+5; with LATENCY=0 -> at cycle N+1.
REQ-037 SHALL verify errors: LOAD 0x1000 with MEM_SIZE=4096, and STORE to 0x42 -> req_fulfilled and req_error both high, req_loaded_word=0, and a subsequent LOAD 0x40 is unchanged.
REQ-038 SHALL verify mid-operation reset: reset_n low during WAIT of STORE 0x11111111 to 0x80 -> no req_fulfilled pulse, state IDLE, and a later LOAD 0x80 returns the old value.
REQ-039 SHALL verify fill sequence: 8 back-to-back LOADs 0x20..0x3C -> 8 pulses spaced LATENCY+2 cycles apart, with read_count=8 (macro defined) or 0 (macro undefined).
REQ-040 SHALL verify stability: change req_address and drop req_valid during WAIT -> the response reflects the originally captured address.
